// File: rtl/stack_rf_pkg.sv
// -----------------------------------------------------------------------------
// stack_rf_pkg
// Shared constants and types for the stack-processor register file.
//   - Architectural register indices (V, SP, GP; the last entry is the zero
//     register).
//   - Default widths and stack-pointer reset/floor/step values.
//   - sp_op_e: the operation selected by the stack-pointer update logic.
// -----------------------------------------------------------------------------
package stack_rf_pkg;

  // Architectural register indices for the default 4-entry file.
  localparam int REG_V  = 0;
  localparam int REG_SP = 1;
  localparam int REG_GP = 2;

  localparam int DATA_W_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT = 2;

  localparam logic [15:0] SP_RESET_DEFAULT = 16'h7fcd;
  localparam logic [15:0] SP_FLOOR_DEFAULT = 16'h4000;
  localparam logic [15:0] SP_STEP_DEFAULT  = 16'h0002;

  // Stack-pointer next-value selection.
  typedef enum logic [1:0] {
    SP_HOLD = 2'd0,
    SP_LOAD = 2'd1,
    SP_DEC  = 2'd2,
    SP_INC  = 2'd3
  } sp_op_e;

endpackage

// File: rtl/stack_reg_file_sp_unit.sv
// -----------------------------------------------------------------------------
// sp_unit
// Stack-pointer register with push/pop update logic, bounds checking and a
// sticky fault flag. Written generically so it can also serve a future
// frame-pointer register.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_i        asynchronous active-high reset (SP <= SP_RESET, fault <= 0)
//   load_i       direct write of load_data_i (highest priority, no checking)
//   load_data_i  value for a direct write
//   push_i       SP <= SP - SP_STEP if the result stays >= SP_FLOOR
//   pop_i        SP <= SP + SP_STEP if the result stays <= SP_RESET
//   sp_o         current SP (register output)
//   sp_rd_o      value a same-edge read port should sample: the current SP,
//                or the post-update SP when READ_NEXT is set
//   fault_o      sticky bounds-violation flag, cleared only by reset
// -----------------------------------------------------------------------------
module sp_unit
  import stack_rf_pkg::*;
#(
  parameter int               DATA_W    = DATA_W_DEFAULT,
  parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEFAULT,
  parameter logic [DATA_W-1:0] SP_FLOOR = SP_FLOOR_DEFAULT,
  parameter logic [DATA_W-1:0] SP_STEP  = SP_STEP_DEFAULT,
  parameter bit               READ_NEXT = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_data_i,
  input  logic              push_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] sp_o,
  output logic [DATA_W-1:0] sp_rd_o,
  output logic              fault_o
);

  logic [DATA_W-1:0] sp_q, sp_d;
  logic              fault_q, fault_d;
  sp_op_e            op;

  // One extra bit so a borrow below zero or a carry past all-ones is seen
  // as out of range instead of wrapping into a legal value.
  logic [DATA_W:0] dec_ext, inc_ext;
  logic            push_bad, pop_bad;

  assign dec_ext  = {1'b0, sp_q} - {1'b0, SP_STEP};
  assign inc_ext  = {1'b0, sp_q} + {1'b0, SP_STEP};
  assign push_bad = dec_ext[DATA_W] || (dec_ext[DATA_W-1:0] < SP_FLOOR);
  assign pop_bad  = inc_ext > {1'b0, SP_RESET};

  always_comb begin
    op      = SP_HOLD;
    fault_d = fault_q;
    if (load_i) begin
      op = SP_LOAD;
    end else if (push_i && pop_i) begin
      op = SP_HOLD;
    end else if (push_i) begin
      if (push_bad) fault_d = 1'b1;
      else          op      = SP_DEC;
    end else if (pop_i) begin
      if (pop_bad) fault_d = 1'b1;
      else         op      = SP_INC;
    end
  end

  always_comb begin
    sp_d = sp_q;
    case (op)
      SP_LOAD: sp_d = load_data_i;
      SP_DEC:  sp_d = dec_ext[DATA_W-1:0];
      SP_INC:  sp_d = inc_ext[DATA_W-1:0];
      default: sp_d = sp_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sp_q    <= SP_RESET;
      fault_q <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      fault_q <= fault_d;
    end
  end

  assign sp_o    = sp_q;
  assign sp_rd_o = READ_NEXT ? sp_d : sp_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/stack_reg_file.sv
// -----------------------------------------------------------------------------
// stack_reg_file
// Register file for the stack processor: N = 2**ADDR_W entries of DATA_W bits,
// two registered read ports, one write port, and a stack pointer (entry
// SP_IDX) with bounds-checked push/pop. Entry N-1 is a hard-wired zero.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset
//   w_data    write data
//   w_addr    write address
//   regWrite  write enable (writes to entry N-1 are dropped)
//   r_addr_a  read port A address; r_data_a registered, 1-cycle latency
//   r_addr_b  read port B address; r_data_b registered, 1-cycle latency
//   sp_push   SP -= SP_STEP (bounded by SP_FLOOR)
//   sp_pop    SP += SP_STEP (bounded by SP_RESET)
//   sp_out    current SP register value
//   sp_fault  sticky bounds-violation flag
//
// Build option: RF_WRITE_BYPASS_EN
//   undefined - a read sampling the entry being written returns the old value.
//   defined   - reads forward w_data (and the post-push/pop SP) on the same
//               edge, removing the need for pipeline hazard stalls.
// -----------------------------------------------------------------------------
module stack_reg_file
  import stack_rf_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEFAULT,
  parameter int                ADDR_W   = ADDR_W_DEFAULT,
  parameter int                SP_IDX   = REG_SP,
  parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_DEFAULT,
  parameter logic [DATA_W-1:0] SP_FLOOR = SP_FLOOR_DEFAULT,
  parameter logic [DATA_W-1:0] SP_STEP  = SP_STEP_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] r_addr_a,
  output logic [DATA_W-1:0] r_data_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  output logic [DATA_W-1:0] r_data_b,
  input  logic              sp_push,
  input  logic              sp_pop,
  output logic [DATA_W-1:0] sp_out,
  output logic              sp_fault
);

  localparam int N        = 2 ** ADDR_W;
  localparam int ZERO_IDX = N - 1;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit READ_NEXT = 1'b1;
`else
  localparam bit READ_NEXT = 1'b0;
`endif

  // Value each entry presents to the read muxes.
  logic [DATA_W-1:0] rd_vals [N];
  logic [DATA_W-1:0] sp_rd;
  logic              wr_hit;
  logic              sp_load;

  assign wr_hit  = regWrite && (w_addr != ADDR_W'(ZERO_IDX));
  assign sp_load = regWrite && (w_addr == ADDR_W'(SP_IDX));

  sp_unit #(
    .DATA_W    (DATA_W),
    .SP_RESET  (SP_RESET),
    .SP_FLOOR  (SP_FLOOR),
    .SP_STEP   (SP_STEP),
    .READ_NEXT (READ_NEXT)
  ) u_sp (
    .clk_i       (clk),
    .rst_i       (reset),
    .load_i      (sp_load),
    .load_data_i (w_data),
    .push_i      (sp_push),
    .pop_i       (sp_pop),
    .sp_o        (sp_out),
    .sp_rd_o     (sp_rd),
    .fault_o     (sp_fault)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_entry
      if (gi == SP_IDX) begin : g_sp
        assign rd_vals[gi] = sp_rd;
      end else if (gi == ZERO_IDX) begin : g_zero
        assign rd_vals[gi] = '0;
      end else begin : g_gpr
        logic [DATA_W-1:0] entry_q;
        always_ff @(posedge clk or posedge reset) begin
          if (reset)                                        entry_q <= '0;
          else if (regWrite && (w_addr == ADDR_W'(gi)))     entry_q <= w_data;
        end
        assign rd_vals[gi] = entry_q;
      end
    end
  endgenerate

  logic [DATA_W-1:0] r_data_a_q, r_data_a_d;
  logic [DATA_W-1:0] r_data_b_q, r_data_b_d;

  always_comb begin
    r_data_a_d = rd_vals[r_addr_a];
`ifdef RF_WRITE_BYPASS_EN
    // The SP entry already forwards its next value via sp_rd.
    if (wr_hit && (r_addr_a == w_addr)) r_data_a_d = w_data;
`endif
  end

  always_comb begin
    r_data_b_d = rd_vals[r_addr_b];
`ifdef RF_WRITE_BYPASS_EN
    if (wr_hit && (r_addr_b == w_addr)) r_data_b_d = w_data;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data_a_q <= '0;
      r_data_b_q <= '0;
    end else begin
      r_data_a_q <= r_data_a_d;
      r_data_b_q <= r_data_b_d;
    end
  end

  assign r_data_a = r_data_a_q;
  assign r_data_b = r_data_b_q;

`ifndef RF_WRITE_BYPASS_EN
  // Only referenced by the forwarding path.
  logic unused_wr_hit;
  assign unused_wr_hit = wr_hit;
`endif

endmodule

// File: tb/tb_stack_reg_file.sv
// -----------------------------------------------------------------------------
// tb_stack_reg_file
// Self-checking bench: directed scenarios followed by random traffic. Each
// issued cycle pushes the expected read data / SP / fault into a scoreboard;
// a monitor pops and compares after every rising edge.
// -----------------------------------------------------------------------------
module tb_stack_reg_file;

  localparam int N      = 4;
  localparam int SPI    = 1;
  localparam int ZI     = 3;
  localparam int SP_RST = 32'h7fcd;
  localparam int FLOOR  = 32'h4000;
  localparam int STEP   = 2;
`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] w_data;
  logic [1:0]  w_addr;
  logic        regWrite;
  logic [1:0]  r_addr_a, r_addr_b;
  logic [15:0] r_data_a, r_data_b;
  logic        sp_push, sp_pop;
  logic [15:0] sp_out;
  logic        sp_fault;

  always #5 clk = ~clk;

  stack_reg_file #(
    .DATA_W   (16),
    .ADDR_W   (2),
    .SP_IDX   (1),
    .SP_RESET (16'h7fcd),
    .SP_FLOOR (16'h4000),
    .SP_STEP  (16'h0002)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .w_data   (w_data),
    .w_addr   (w_addr),
    .regWrite (regWrite),
    .r_addr_a (r_addr_a),
    .r_data_a (r_data_a),
    .r_addr_b (r_addr_b),
    .r_data_b (r_data_b),
    .sp_push  (sp_push),
    .sp_pop   (sp_pop),
    .sp_out   (sp_out),
    .sp_fault (sp_fault)
  );

  typedef struct {
    int a;
    int b;
    int sp;
    bit f;
  } exp_t;

  exp_t sb[$];
  int   model[N];
  bit   mfault;
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) model[i] = 0;
    model[SPI] = SP_RST;
    mfault     = 1'b0;
  endfunction

  // Drive one cycle of stimulus, predict its outcome, wait past the edge.
  task automatic cycle(input bit we, input int wa, input int wd, input int ra,
                       input int rb, input bit push, input bit pop);
    int   old_m[N];
    int   new_m[N];
    exp_t e;
    @(negedge clk);
    regWrite = we;
    w_addr   = 2'(wa);
    w_data   = 16'(wd);
    r_addr_a = 2'(ra);
    r_addr_b = 2'(rb);
    sp_push  = push;
    sp_pop   = pop;

    old_m = model;
    new_m = model;
    if (we && wa != ZI) new_m[wa] = wd & 32'hffff;
    if (!(we && wa == SPI)) begin
      if (push && pop) begin
        // no change
      end else if (push) begin
        if (model[SPI] - STEP < FLOOR) mfault = 1'b1;
        else new_m[SPI] = model[SPI] - STEP;
      end else if (pop) begin
        if (model[SPI] + STEP > SP_RST) mfault = 1'b1;
        else new_m[SPI] = model[SPI] + STEP;
      end
    end
    e.a  = BYP ? new_m[ra] : old_m[ra];
    e.b  = BYP ? new_m[rb] : old_m[rb];
    e.sp = new_m[SPI];
    e.f  = mfault;
    model = new_m;
    sb.push_back(e);
    @(posedge clk);
    #2;
    $display("[TB] t=%0t we=%0d wa=%0d wd=%h ra=%0d rb=%0d push=%0d pop=%0d -> a=%h b=%h sp=%h f=%0d",
             $time, we, wa, 16'(wd), ra, rb, push, pop, r_data_a, r_data_b, sp_out, sp_fault);
  endtask

  task automatic idle_inputs();
    regWrite = 1'b0; w_addr = '0; w_data = '0;
    r_addr_a = '0; r_addr_b = '0; sp_push = 1'b0; sp_pop = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    sb.delete();
  endtask

  // Monitor: compares registered outputs one step after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_a", {16'h0, r_data_a}, e.a);
        chk("rd_b", {16'h0, r_data_b}, e.b);
        chk("sp_out", {16'h0, sp_out}, e.sp);
        chk("sp_fault", {31'h0, sp_fault}, {31'h0, e.f});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rst[4];
    int wd, wa;
    bit we, push, pop;
    exp_rst[0] = 0; exp_rst[1] = 32'h7fcd; exp_rst[2] = 0; exp_rst[3] = 0;

    idle_inputs();
    reset = 1'b1;
    model_reset();
    #3;
    chk("rst_rd_a", {16'h0, r_data_a}, 0);
    chk("rst_rd_b", {16'h0, r_data_b}, 0);
    chk("rst_sp", {16'h0, sp_out}, 32'h7fcd);
    chk("rst_fault", {31'h0, sp_fault}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: read every entry on both ports
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, i, i, 0, 0);
      chk("t1_rd_a", {16'h0, r_data_a}, exp_rst[i]);
      chk("t1_rd_b", {16'h0, r_data_b}, exp_rst[i]);
    end
    chk("t1_fault", {31'h0, sp_fault}, 0);

    // 2: same-edge read of the written entry
    cycle(1, 0, 32'hbeef, 0, 2, 0, 0);
    chk("t2_same", {16'h0, r_data_a}, BYP ? 32'hbeef : 0);
    cycle(0, 0, 0, 0, 0, 0, 0);
    chk("t2_next", {16'h0, r_data_a}, 32'hbeef);

    // 3: push x3, pop x3, over-pop faults and stays faulted
    for (int k = 0; k < 3; k++) begin
      cycle(0, 0, 0, 1, 0, 1, 0);
      chk("t3_push", {16'h0, sp_out}, 32'h7fcd - 2 * (k + 1));
    end
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 1, 0, 1);
    chk("t3_pop", {16'h0, sp_out}, 32'h7fcd);
    chk("t3_nofault", {31'h0, sp_fault}, 0);
    cycle(0, 0, 0, 1, 1, 0, 1);
    chk("t3_overpop_sp", {16'h0, sp_out}, 32'h7fcd);
    chk("t3_overpop_f", {31'h0, sp_fault}, 1);
    cycle(0, 0, 0, 1, 1, 1, 0);
    cycle(0, 0, 0, 1, 1, 1, 0);
    chk("t3_sticky_sp", {16'h0, sp_out}, 32'h7fc9);
    chk("t3_sticky_f", {31'h0, sp_fault}, 1);

    // 4: floor boundary
    reset_dut();
    cycle(1, 1, 32'h4001, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 1, 0);
    chk("t4_under_sp", {16'h0, sp_out}, 32'h4001);
    chk("t4_under_f", {31'h0, sp_fault}, 1);
    reset_dut();
    cycle(1, 1, 32'h4002, 1, 1, 0, 0);
    cycle(0, 0, 0, 1, 1, 1, 0);
    chk("t4_floor_sp", {16'h0, sp_out}, 32'h4000);
    chk("t4_floor_f", {31'h0, sp_fault}, 0);

    // 5: write wins over push+pop; push+pop alone holds
    cycle(1, 1, 32'h1234, 1, 1, 1, 1);
    chk("t5_wr_sp", {16'h0, sp_out}, 32'h1234);
    cycle(0, 0, 0, 1, 1, 1, 1);
    chk("t5_pp_sp", {16'h0, sp_out}, 32'h1234);
    chk("t5_pp_f", {31'h0, sp_fault}, 0);

    // 6: zero register, then asynchronous reset mid-cycle
    cycle(1, 3, 32'hffff, 3, 3, 0, 0);
    cycle(0, 0, 0, 3, 3, 0, 0);
    chk("t6_zero", {16'h0, r_data_a}, 0);
    cycle(1, 0, 32'hbeef, 1, 0, 0, 0);
    cycle(1, 1, 32'h7fcd, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk("t6_pre_f", {31'h0, sp_fault}, 1);
    @(negedge clk);
    sp_push = 1'b1;
    r_addr_a = 2'd0;
    #2;
    reset = 1'b1;
    #1;
    chk("t6_async_rd_a", {16'h0, r_data_a}, 0);
    chk("t6_async_sp", {16'h0, sp_out}, 32'h7fcd);
    chk("t6_async_f", {31'h0, sp_fault}, 0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    model_reset();
    sb.delete();
    cycle(0, 0, 0, 0, 2, 0, 0);
    chk("t6_post_reg0", {16'h0, r_data_a}, 0);

    // Random traffic, two phases separated by a reset
    for (int n = 0; n < 400; n++) begin
      if (n == 200) reset_dut();
      we   = ($urandom_range(0, 2) == 0);
      wa   = $urandom_range(0, 3);
      wd   = $urandom_range(0, 32'hffff);
      if (we && wa == SPI) begin
        case ($urandom_range(0, 2))
          0: wd = FLOOR + $urandom_range(0, 5);
          1: wd = SP_RST - $urandom_range(0, 5);
          default: wd = $urandom_range(0, 32'hffff);
        endcase
      end
      push = ($urandom_range(0, 9) < 4);
      pop  = ($urandom_range(0, 9) < 4);
      cycle(we, wa, wd, $urandom_range(0, 3), $urandom_range(0, 3), push, pop);
    end

    @(negedge clk);
    idle_inputs();
    for (int t = 0; t < 10 && sb.size() > 0; t++) @(negedge clk);
    if (sb.size() > 0) chk("drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stack_reg_file.md
Name: stack_reg_file

Overview:
Parametrised next-generation register file for the stack processor.
- Generalises the 3-live-register, 1-port file to N = 2**ADDR_W entries of DATA_W bits.
- Two independent registered read ports and one write port.
- The stack pointer has dedicated push/pop update logic with bounds checking.
- Sits between the decode stage and the ALU/memory-address path.

Parameters:
- DATA_W, 16, width of every register and data port
- ADDR_W, 2, register address width; N = 2**ADDR_W entries
- SP_IDX, 1, index of the stack-pointer register
- SP_RESET, 16'h7fcd, SP value after reset; also the pop (upper) bound
- SP_FLOOR, 16'h4000, lowest legal SP value (push bound)
- SP_STEP, 2, bytes added/subtracted per pop/push

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- w_data  input  DATA_W  write data
- w_addr  input  ADDR_W  write address
- regWrite  input  1  write enable
- r_addr_a  input  ADDR_W  read port A address
- r_data_a  output  DATA_W  read port A data, registered
- r_addr_b  input  ADDR_W  read port B address
- r_data_b  output  DATA_W  read port B data, registered
- sp_push  input  1  decrement SP by SP_STEP
- sp_pop  input  1  increment SP by SP_STEP
- sp_out  output  DATA_W  current SP, combinational from the SP register
- sp_fault  output  1  sticky bounds-violation flag

Behaviour:
- Reset (asynchronous, immediate, also mid-operation):
  - all registers 0, except reg[SP_IDX] = SP_RESET;
  - r_data_a, r_data_b = 0; sp_fault = 0.
- Zero register, index N-1:
  - always reads 0;
  - writes to it are ignored.
- Reads:
  - every cycle, both ports register reg[r_addr_*] at the rising edge; latency 1 cycle.
  - Reads are not suppressed by regWrite (fixes the prior read-blocked-during-write behaviour).
  - Same-edge read of the address being written returns the OLD value (macro off).
- Writes: when regWrite=1 and w_addr != N-1, reg[w_addr] <= w_data at the edge.
- SP update, priority highest first:
  1. regWrite && w_addr==SP_IDX: SP <= w_data; push/pop ignored; no fault check.
  2. sp_push && sp_pop: no change.
  3. sp_push:
     - if SP - SP_STEP < SP_FLOOR (unsigned, including underflow wrap): SP unchanged, sp_fault <= 1;
     - else SP <= SP - SP_STEP.
  4. sp_pop:
     - if SP + SP_STEP > SP_RESET (unsigned, including overflow wrap): SP unchanged, sp_fault <= 1;
     - else SP <= SP + SP_STEP.
- Bound checks are computed at DATA_W+1 bits so the carry/borrow is detected.
- SP_FLOOR and SP_RESET themselves are legal values.
- sp_fault is sticky and cleared only by reset.
- A read of SP in the same cycle as push/pop returns the pre-update value.
- sp_out reflects the updated SP the cycle after the edge.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: a read port whose address equals w_addr while regWrite=1 (w_addr != N-1) registers w_data instead of the stored value.
  - A read of SP_IDX during a legal push/pop registers the post-update SP.
- Undefined: old-value read semantics as above. Fewer muxes; the pipeline must insert hazard stalls.

Decomposition:
- Package stack_rf_pkg:
  - index constants REG_V=0, REG_SP=1, REG_GP=2;
  - default DATA_W/ADDR_W;
  - SP_RESET_DEFAULT, SP_FLOOR_DEFAULT, SP_STEP_DEFAULT.
- Sub-module sp_unit:
  - SP next-value mux, bounds comparators, sticky fault flop;
  - instantiated once in stack_reg_file; reusable by a future frame-pointer register.

Test Plan:
1. Reset, then read all addresses on both ports -> 0x0000, 0x7fcd, 0x0000, 0x0000; sp_fault=0.
2. Write 0xBEEF to addr 0 and read addr 0 on A in the same cycle:
   - macro off -> A=0x0000, next read 0xBEEF;
   - macro on -> A=0xBEEF immediately.
3. Push x3 from reset -> sp_out 0x7fcb, 0x7fc9, 0x7fc7; then pop x3 -> back to 0x7fcd; a further pop -> SP stays 0x7fcd, sp_fault=1 and stays 1 through subsequent legal pushes.
4. Write SP=0x4001, then push -> SP unchanged 0x4001, sp_fault=1. Write SP=0x4002, then push -> 0x4000, no new fault.
5. regWrite SP=0x1234 with sp_push=1 and sp_pop=1 asserted together -> SP=0x1234. push+pop alone -> SP unchanged.
6. Write 0xFFFF to addr 3 -> reads 0. Assert reset asynchronously mid-cycle during a push -> outputs return to reset values before the next edge.
